step_gen: RTL and testbench
===========================

STEP_GEN -- requirements
Module: step_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required to accept a press or release (10 ms at 50 MHz), minimum 2.
REQ-002 Parameter REPEAT_CYCLES, default 25000000, hold time between auto-repeat steps (used only with AUTO_REPEAT_EN).
REQ-003 CLOCK_50  input  1  single system clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 key_n  input  1  raw pushbutton, active-low, asynchronous, bouncy.
REQ-006 w_in  input  1  raw data switch, asynchronous.
REQ-007 step  output  1  one-cycle pulse per accepted press; drives the downstream sequence-detector clock enable.
REQ-008 w_out  output  1  synchronized w_in, captured on the cycle step asserts; held otherwise.
REQ-009 press_cnt  output  8  count of step pulses, for LEDR display.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 key_n and w_in SHALL each pass through a two-flop synchronizer before any use; key_s and w_s are the synchronized values.
REQ-012 The FSM SHALL have states IDLE, PRESS_WAIT, HELD, and RELEASE_WAIT, with a debounce counter wide enough for max(DEBOUNCE_CYCLES, REPEAT_CYCLES).
REQ-013 IDLE: key_s=0 -> PRESS_WAIT, with the counter cleared; otherwise stay.
REQ-014 PRESS_WAIT: key_s=1 (bounce) -> IDLE, with the counter cleared and no step; counter reaching DEBOUNCE_CYCLES-1 with key_s=0 -> HELD.
REQ-015 The PRESS_WAIT->HELD transition SHALL assert step for exactly one cycle, load w_out<=w_s, and increment press_cnt.
REQ-016 Latency: if key_n is low and stable from clock edge 1, step SHALL be high for exactly the one cycle following edge 2+DEBOUNCE_CYCLES.
REQ-017 HELD: key_s=1 -> RELEASE_WAIT, with the counter cleared; otherwise stay with no further step (unless AUTO_REPEAT_EN).
REQ-018 RELEASE_WAIT: key_s=0 -> HELD, with no step; counter reaching DEBOUNCE_CYCLES-1 with key_s=1 -> IDLE.
REQ-019 press_cnt SHALL wrap 255->0 without saturation or flag.
REQ-020 Changes to w_in SHALL affect w_out only at a step pulse.
REQ-021 At most one step SHALL be issued per debounced press.

Reset
REQ-022 Asserting reset SHALL force IDLE and set counter=0, step=0, w_out=0, press_cnt=0, and busy=0, immediately and independently of the clock.
REQ-023 Reset mid-debounce SHALL discard the pending press with no step; synchronizer flops SHALL reset to 1 (key) and 0 (w).
REQ-024 After reset deasserts with key_n held low, a full press SHALL be re-qualified (IDLE->PRESS_WAIT).

Configuration
REQ-025 Macro STEP_GEN_AUTO_REPEAT_EN: when defined, HELD with key_s=0 for REPEAT_CYCLES consecutive cycles SHALL issue another step, capture w_out, increment press_cnt, and restart the repeat count.
REQ-026 When STEP_GEN_AUTO_REPEAT_EN is undefined, no repeat logic SHALL be present and REPEAT_CYCLES SHALL be ignored.

Structure
REQ-027 Package step_gen_pkg SHALL hold the state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and default constants for DEBOUNCE_CYCLES and REPEAT_CYCLES.
REQ-028 Sub-module sync2 (parameterless two-flop synchronizer with async reset value port) SHALL be instantiated twice.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10)
REQ-029 Clean press: key_n low from edge 1 with w_in=1 -> step high only after edge 6; w_out=1; press_cnt=1; release for 4 cycles -> IDLE, busy=0.
REQ-030 Bounce: key_n low for 2 cycles, high for 1 cycle, then low steadily -> no step until 4 stable low cycles; exactly one step total.
REQ-031 Release bounce: in HELD, key_n high 2 cycles then low -> returns to HELD with no extra step; press_cnt unchanged.
REQ-032 Wrap: 256 clean presses -> press_cnt=0; w_out follows w_in value at each step.
REQ-033 Reset mid-operation: reset asserted during PRESS_WAIT at count 2 -> all outputs 0 immediately; no step after deassert until the full press is re-qualified.
REQ-034 With STEP_GEN_AUTO_REPEAT_EN, key held 30 cycles past first step -> steps at +10, +20, +30 cycles; press_cnt=4.

Source files
------------

// File: rtl/step_gen_pkg.sv
// Shared types and default timing constants for the step_gen pushbutton stepper.
package step_gen_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
    localparam int unsigned REPEAT_CYCLES_DEF   = 25000000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer whose asynchronous reset value is supplied by a port.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= rst_val;
            q    <= rst_val;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/step_gen.sv
// Debounced pushbutton single-stepper: one step pulse per qualified press, capturing w_in.
// Optional auto-repeat while held is enabled by defining STEP_GEN_AUTO_REPEAT_EN.
module step_gen
    import step_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_n,
    input  logic       w_in,
    output logic       step,
    output logic       w_out,
    output logic [7:0] press_cnt,
    output logic       busy
);

    localparam int unsigned CNT_MAX = max_u(DEBOUNCE_CYCLES, REPEAT_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    // Entry into a wait state is the first stable sample, so the exit fires one count early.
    localparam int unsigned DEB_LAST = DEBOUNCE_CYCLES - 2;

    logic             key_s;
    logic             w_s;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             step_next;

    sync2 u_sync_key (
        .clk     (CLOCK_50),
        .reset   (reset),
        .rst_val (1'b1),
        .d       (key_n),
        .q       (key_s)
    );

    sync2 u_sync_w (
        .clk     (CLOCK_50),
        .reset   (reset),
        .rst_val (1'b0),
        .d       (w_in),
        .q       (w_s)
    );

    // Next-state, debounce counter and step decision
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        step_next  = 1'b0;
        case (state)
            IDLE: begin
                if (!key_s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_W'(DEB_LAST)) begin
                    state_next = HELD;
                    cnt_next   = '0;
                    step_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (key_s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
`ifdef STEP_GEN_AUTO_REPEAT_EN
                else if (cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
                    cnt_next  = '0;
                    step_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
`endif
            end
            RELEASE_WAIT: begin
                if (!key_s) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt == CNT_W'(DEB_LAST)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            step      <= 1'b0;
            w_out     <= 1'b0;
            press_cnt <= 8'd0;
            busy      <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            step  <= step_next;
            busy  <= (state_next != IDLE);
            if (step_next) begin
                w_out     <= w_s;
                press_cnt <= press_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_step_gen.sv
// Scoreboard bench for step_gen with short debounce/repeat timing.
module tb_step_gen;

    localparam int unsigned D = 4;
    localparam int unsigned R = 10;

    typedef struct {
        int         cyc;
        logic       w;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_n;
    logic       w_in;
    logic       step;
    logic       w_out;
    logic [7:0] press_cnt;
    logic       busy;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cnt;
    exp_t       q[$];

    step_gen #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_CYCLES   (R)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .key_n     (key_n),
        .w_in      (w_in),
        .step      (step),
        .w_out     (w_out),
        .press_cnt (press_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_step(input int at, input logic w);
        exp_t e;
        exp_cnt = exp_cnt + 8'd1;
        e.cyc = at;
        e.w   = w;
        e.cnt = exp_cnt;
        q.push_back(e);
    endtask

    // Clean press held 'hold' cycles past the step, then a full release.
    task automatic press(input logic w, input int hold);
        expect_step(cyc + int'(D) + 2, w);
        w_in  = w;
        key_n = 1'b0;
        tick(int'(D) + 2 + hold);
        key_n = 1'b1;
        tick(int'(D) + 4);
        chk("busy_after_release", int'(busy), 0);
    endtask

    // Monitor: every step pulse must match the oldest expected step
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && step) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_step actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("step_cycle", cyc, e.cyc);
                chk("step_w_out", int'(w_out), int'(e.w));
                chk("step_press_cnt", int'(press_cnt), int'(e.cnt));
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int m;
        reset   = 1'b1;
        key_n   = 1'b1;
        w_in    = 1'b0;
        exp_cnt = 8'd0;
        tick(2);
        chk("rst_step", int'(step), 0);
        chk("rst_w_out", int'(w_out), 0);
        chk("rst_press_cnt", int'(press_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        tick(3);
        chk("idle_busy", int'(busy), 0);

        // Clean press with latency and release boundaries
        n = cyc;
        expect_step(n + 6, 1'b1);
        w_in  = 1'b1;
        key_n = 1'b0;
        tick(5);
        chk("step_not_early", int'(step), 0);
        chk("busy_press_wait", int'(busy), 1);
        tick(2);
        chk("step_one_cycle", int'(step), 0);
        tick(3);
        m = cyc;
        key_n = 1'b1;
        tick(5);
        chk("busy_release_wait", int'(busy), 1);
        tick(1);
        chk("busy_idle_after_release", int'(busy), 0);
        chk("clean_press_cnt", int'(press_cnt), 1);
        w_in = 1'b0;
        tick(5);
        chk("w_out_holds", int'(w_out), 1);

        // Press bounce: 2 low, 1 high, then steady low
        n = cyc;
        expect_step(n + 9, 1'b0);
        key_n = 1'b0;
        tick(2);
        key_n = 1'b1;
        tick(1);
        key_n = 1'b0;
        tick(8);
        key_n = 1'b1;
        tick(8);
        chk("bounce_busy", int'(busy), 0);

        // Release bounce while held
        n = cyc;
        w_in = 1'b1;
        expect_step(n + 6, 1'b1);
        key_n = 1'b0;
        tick(7);
        key_n = 1'b1;
        tick(2);
        key_n = 1'b0;
        tick(4);
        chk("relbounce_busy_held", int'(busy), 1);
        chk("relbounce_cnt", int'(press_cnt), 3);
        key_n = 1'b1;
        tick(8);
        chk("relbounce_busy_idle", int'(busy), 0);

        // Reset during PRESS_WAIT at count 2
        key_n = 1'b0;
        tick(5);
        reset = 1'b1;
        #1;
        chk("midrst_step", int'(step), 0);
        chk("midrst_w_out", int'(w_out), 0);
        chk("midrst_press_cnt", int'(press_cnt), 0);
        chk("midrst_busy", int'(busy), 0);
        tick(2);
        reset   = 1'b0;
        exp_cnt = 8'd0;
        n = cyc;
        expect_step(n + 6, 1'b1);
        tick(5);
        chk("requal_not_early", int'(step), 0);
        tick(3);
        key_n = 1'b1;
        tick(8);
        chk("requal_press_cnt", int'(press_cnt), 1);

        // 256 presses wrap the counter back to zero
        reset = 1'b1;
        tick(1);
        reset   = 1'b0;
        exp_cnt = 8'd0;
        tick(2);
        for (int i = 0; i < 256; i++) begin
            press(((i % 3) == 0) || ((i % 7) == 2), 2);
        end
        chk("wrap_press_cnt", int'(press_cnt), 0);

`ifdef STEP_GEN_AUTO_REPEAT_EN
        // Held key repeats every R cycles after the first step
        n = cyc;
        w_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_step(n + 6 + k * int'(R), 1'b1);
        end
        key_n = 1'b0;
        tick(37);
        key_n = 1'b1;
        tick(8);
        chk("repeat_press_cnt", int'(press_cnt), 4);
`endif

        for (int k = 0; k < 20 && q.size() > 0; k++) begin
            tick(1);
        end
        chk("pending_steps", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
